pnu_mux_scan: RTL and testbench
===============================

PNU_MUX_SCAN -- requirements
Module: pnu_mux_scan

Interface
REQ-001 SHALL have parameter SETTLE, default 1: number of idle settle cycles after each select change before sampling; legal range 0..15.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request one 8-input scan; sampled on the clk rising edge.
REQ-005 SHALL have port sel  output  3  select to the downstream 8:1 mux; sel[2]=e1, sel[1]=e2, sel[0]=e3.
REQ-006 SHALL have port mux_in  input  1  mux output o1 returned for sampling.
REQ-007 SHALL have port busy  output  1  high from the edge that accepts start until the edge where out_valid rises.
REQ-008 SHALL have port out_data  output  8  captured word; bit k = mux_in sampled while sel==k.
REQ-009 SHALL have port out_valid  output  1  out_data is complete and held stable.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data when high with out_valid.

Function
REQ-011 SHALL implement states IDLE, SETTLE, SAMPLE, OUTPUT.
REQ-012 IDLE: start=1 at an edge -> sel=0, settle counter=0, busy=1; next state SETTLE, or SAMPLE if SETTLE==0.
REQ-013 SETTLE: counter increments each edge; after SETTLE edges in this state -> SAMPLE.
REQ-014 SAMPLE: single cycle; at its edge, out_data[sel] <= mux_in; if sel<7 then sel increments, counter clears, next state SETTLE (or SAMPLE if SETTLE==0); if sel==7 then next state OUTPUT, out_valid=1, busy=0.
REQ-015 Timing: with start accepted at edge E0, bit k SHALL be captured at edge E0+(k+1)*(SETTLE+1); out_valid SHALL rise at edge E0+8*(SETTLE+1).
REQ-016 sel SHALL change only at the edge that enters SETTLE/SAMPLE for a new index; it SHALL stay stable throughout each settle window and in OUTPUT it SHALL hold 7.
REQ-017 OUTPUT: out_data and out_valid held until an edge with out_ready=1; at that edge out_valid <= 0 and state -> IDLE.
REQ-018 Back-to-back: if start=1 at the same edge out_ready accepts, a new scan SHALL begin at that edge (sel=0) without an IDLE cycle.
REQ-019 start SHALL be ignored in SETTLE, SAMPLE and in OUTPUT without out_ready.
REQ-020 out_data bits not yet captured in the current scan SHALL retain previous-scan values; out_data is valid only while out_valid=1.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, sel=0, counter=0, out_data=8'h00, out_valid=0, busy=0, and parity=0 where present, regardless of clk.
REQ-022 Reset asserted mid-scan SHALL abandon the scan; after release no out_valid until a new start.

Configuration
REQ-023 Macro PNU_MUX_SCAN_PARITY_EN defined: extra output out_parity (1 bit) = XOR of out_data, registered and updated with out_valid's rise; held in OUTPUT.
REQ-024 Macro not defined: port out_parity absent; all other behaviour identical.

Structure
REQ-025 Shared package pnu_pkg SHALL hold the state enum type and constants SEL_W=3, NUM_IN=8, SETTLE_MAX=15.
REQ-026 Sub-module pnu_settle_cnt (load/clear, increment, terminal-count flag) SHALL implement the settle counter; FSM and capture register stay in pnu_mux_scan.

Verification
REQ-027 SETTLE=1, mux_in driven from a model of the 8:1 mux with inputs 8'hA5, start pulse at E0 -> out_valid rises at E16, out_data=8'hA5, sel sequence 0..7 each held 2 cycles.
REQ-028 SETTLE=0, inputs 8'h3C, out_ready tied 1, start held 1 -> consecutive words 8'h3C every 9 cycles with no IDLE gap.
REQ-029 out_ready low for 5 cycles after out_valid, input pattern changed meanwhile -> out_data stays at captured value, start pulses ignored.
REQ-030 rst_n pulled low at E5 of a scan between clock edges -> all outputs zero immediately, no out_valid after release until start.
REQ-031 PNU_MUX_SCAN_PARITY_EN defined, inputs 8'h07 -> out_parity=1 with out_valid; inputs 8'h03 -> out_parity=0.
REQ-032 start pulsed at E3 during an active scan -> ignored; exactly one out_valid at E16 (SETTLE=1).

Source files
------------

// File: rtl/pnu_pkg.sv
// pnu_pkg: shared types and constants for the mux scanner.
// Scan FSM state enum plus select/settle widths.
package pnu_pkg;

    localparam int SEL_W      = 3;
    localparam int NUM_IN     = 8;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_OUTPUT
    } state_e;

endpackage

// File: rtl/pnu_settle_cnt.sv
// pnu_settle_cnt: settle-window counter for the mux scanner.
// Clear, increment, and a flag on the last settle edge.
module pnu_settle_cnt
    import pnu_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // this edge completes the settle window
    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/pnu_mux_scan.sv
// pnu_mux_scan: steps sel 0..7, settles, samples mux_in into out_data.
// Define PNU_MUX_SCAN_PARITY_EN to add the registered out_parity output.
module pnu_mux_scan
    import pnu_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [SEL_W-1:0] sel,
    input  logic             mux_in,
    output logic             busy,
    output logic [NUM_IN-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef PNU_MUX_SCAN_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam state_e FIRST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_IN - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [NUM_IN-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                cnt_clr, cnt_inc, cnt_tc;
`ifdef PNU_MUX_SCAN_PARITY_EN
    logic                par_q, par_d;
`endif

    pnu_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    // next state, select stepping, capture and handshake
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`ifdef PNU_MUX_SCAN_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = '0;
                    cnt_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = FIRST;
                end
            end
            S_SETTLE: begin
                cnt_inc = 1'b1;
                if (cnt_tc) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                data_d[sel_q] = mux_in;
                if (sel_q != LAST_SEL) begin
                    sel_d   = sel_q + 1'b1;
                    cnt_clr = 1'b1;
                    state_d = FIRST;
                end else begin
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_OUTPUT;
`ifdef PNU_MUX_SCAN_PARITY_EN
                    par_d   = ^data_d;
`endif
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (start) begin
                        sel_d   = '0;
                        cnt_clr = 1'b1;
                        busy_d  = 1'b1;
                        state_d = FIRST;
                    end
                end
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PNU_MUX_SCAN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef PNU_MUX_SCAN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
`ifdef PNU_MUX_SCAN_PARITY_EN
    assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_pnu_mux_scan.sv
// tb_pnu_mux_scan: scoreboard bench for pnu_mux_scan.
// Instance u_dut uses SETTLE=1, u_dut0 uses SETTLE=0.
module tb_pnu_mux_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, out_ready;
    logic [2:0] sel;
    logic       mux_in, busy, out_valid;
    logic [7:0] out_data, pat;

    logic       start0;
    logic [2:0] sel0;
    logic       mux_in0, busy0, out_valid0;
    logic [7:0] out_data0, pat0;
    logic       out_ready0 = 1'b1;
`ifdef PNU_MUX_SCAN_PARITY_EN
    logic       out_parity, out_parity0;
`endif

    logic [7:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         vrise = 0;
    logic       vprev = 1'b0;
    int         e0;

    always #5 clk = ~clk;

    assign mux_in  = pat[sel];
    assign mux_in0 = pat0[sel0];

    pnu_mux_scan #(.SETTLE(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .mux_in    (mux_in),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PNU_MUX_SCAN_PARITY_EN
        ,.out_parity(out_parity)
`endif
    );

    pnu_mux_scan #(.SETTLE(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .sel       (sel0),
        .mux_in    (mux_in0),
        .busy      (busy0),
        .out_data  (out_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready0)
`ifdef PNU_MUX_SCAN_PARITY_EN
        ,.out_parity(out_parity0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: pop on each accepted word, count valid rises
    always @(negedge clk) begin
        logic [7:0] e;
        if (out_valid && !vprev) vrise <= vrise + 1;
        vprev <= out_valid;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_word", {24'd0, out_data}, {24'd0, e});
`ifdef PNU_MUX_SCAN_PARITY_EN
                chk("sb_parity", {31'd0, out_parity}, {31'd0, ^e});
`endif
            end
        end
    end

    task automatic pulse_start(input logic [7:0] p);
        @(posedge clk);
        #1 pat = p;
        start = 1'b1;
        exp_q.push_back(p);
        @(posedge clk);
        #1 start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = cyc - e0;
                break;
            end
        end
        if (lat < 0) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("valid_clr", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int lat, v0, t0, nr;
        int rises[3];
        logic p0;
        rst_n = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        out_ready = 1'b0;
        pat = 8'h00;
        pat0 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", {29'd0, sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SETTLE=1 scan of A5, sel held two cycles per index
        pulse_start(8'hA5);
        chk("t27_busy", {31'd0, busy}, 32'd1);
        chk("t27_sel0", {29'd0, sel}, 32'd0);
        for (int j = 1; j < 16; j++) begin
            @(posedge clk);
            #1;
            chk("t27_sel", {29'd0, sel}, j / 2);
            chk("t27_novalid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("t27_lat", cyc - e0, 32'd16);
        chk("t27_valid", {31'd0, out_valid}, 32'd1);
        chk("t27_busy_lo", {31'd0, busy}, 32'd0);
        chk("t27_sel7", {29'd0, sel}, 32'd7);
        chk("t27_data", {24'd0, out_data}, 32'h A5);
        accept();

        // hold off out_ready, change inputs, poke start
        pulse_start(8'h5A);
        wait_valid(lat);
        chk("t29_lat", lat, 32'd16);
        pat = 8'hFF;
        for (int j = 0; j < 5; j++) begin
            start = j[0];
            @(posedge clk);
            #1;
            chk("t29_data", {24'd0, out_data}, 32'h5A);
            chk("t29_valid", {31'd0, out_valid}, 32'd1);
            chk("t29_busy", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;
        accept();
        v0 = vrise;
        repeat (20) @(posedge clk);
        #1 chk("t29_idle", vrise - v0, 32'd0);

        // start at E3 mid-scan is ignored
        v0 = vrise;
        pulse_start(8'hC3);
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_valid(lat);
        chk("t32_lat", lat, 32'd16);
        chk("t32_data", {24'd0, out_data}, 32'hC3);
        accept();
        repeat (20) @(posedge clk);
        #1 chk("t32_one", vrise - v0, 32'd1);

        // SETTLE=0, start held, ready tied high
        pat0 = 8'h3C;
        @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        nr = 0;
        p0 = 1'b0;
        for (int i = 0; i < 60 && nr < 3; i++) begin
            @(posedge clk);
            #1;
            if (out_valid0 && !p0) begin
                rises[nr] = cyc - t0;
                chk("t28_data", {24'd0, out_data0}, 32'h3C);
                nr++;
            end
            p0 = out_valid0;
        end
        chk("t28_count", nr, 32'd3);
        chk("t28_first", rises[0], 32'd8);
        chk("t28_gap1", rises[1] - rises[0], 32'd9);
        chk("t28_gap2", rises[2] - rises[1], 32'd9);
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t28_stop", {31'd0, out_valid0 | busy0}, 32'd0);

`ifdef PNU_MUX_SCAN_PARITY_EN
        pulse_start(8'h07);
        wait_valid(lat);
        chk("t31_par1", {31'd0, out_parity}, 32'd1);
        accept();
        pulse_start(8'h03);
        wait_valid(lat);
        chk("t31_par0", {31'd0, out_parity}, 32'd0);
        accept();
`endif

        // asynchronous reset mid-scan, between edges
        pulse_start(8'hA5);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t30_sel", {29'd0, sel}, 32'd0);
        chk("t30_busy", {31'd0, busy}, 32'd0);
        chk("t30_data", {24'd0, out_data}, 32'd0);
        chk("t30_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vrise;
        repeat (24) @(posedge clk);
        #1;
        chk("t30_noval", vrise - v0, 32'd0);
        chk("t30_idle", {31'd0, busy}, 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
